// File: rtl/moment_divider.sv
// Fixed-point velocity divider: ux = pux/p and uy = puy/p on two restoring datapaths sharing one denominator.
// Latency: div_valid pulses DATA_WIDTH+FRAC_BITS+2 cycles after an accepted start; starts while busy are dropped.
module moment_divider #(
    parameter int DATA_WIDTH       = 32,
    parameter int FRAC_BITS        = 16,
    parameter int ITER_COUNT_WIDTH = $clog2(DATA_WIDTH + FRAC_BITS + 1)
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  div_start,
    input  logic [DATA_WIDTH-1:0] p_in,
    input  logic [DATA_WIDTH-1:0] pux_in,
    input  logic [DATA_WIDTH-1:0] puy_in,
    output logic [DATA_WIDTH-1:0] ux_out,
    output logic [DATA_WIDTH-1:0] uy_out,
    output logic                  div_valid,
    output logic                  div_busy,
    output logic                  div_by_zero,
    output logic                  div_overflow
);

    localparam int DW = DATA_WIDTH;
    localparam int N  = DATA_WIDTH + FRAC_BITS;

    localparam logic [ITER_COUNT_WIDTH-1:0] LAST_ITER = ITER_COUNT_WIDTH'(N - 1);
    localparam logic [N-1:0] POS_MAX = {{(FRAC_BITS + 1){1'b0}}, {(DW - 1){1'b1}}};
    localparam logic [N-1:0] NEG_LIM = {{FRAC_BITS{1'b0}}, 1'b1, {(DW - 1){1'b0}}};

    typedef enum logic [1:0] {IDLE, ITER, FIXUP, DONE} state_t;

    state_t                      state;
    logic [ITER_COUNT_WIDTH-1:0] cnt;
    logic [DW-1:0]               p_mag;
    logic [N-1:0]                x_dvd;
    logic [N-1:0]                y_dvd;
    logic [DW:0]                 x_rem;
    logic [DW:0]                 y_rem;
    logic [N-1:0]                x_q;
    logic [N-1:0]                y_q;
    logic                        sign_x;
    logic                        sign_y;
    logic                        zero;

    logic [DW+1:0]               x_step;
    logic [DW+1:0]               y_step;
    logic [DW:0]                 x_fix;
    logic [DW:0]                 y_fix;

    function automatic logic [DW-1:0] mag(input logic [DW-1:0] v);
        return v[DW-1] ? -v : v;
    endfunction

    // Returns {quotient bit, next partial remainder}.
    function automatic logic [DW+1:0] step(input logic [DW:0] rem, input logic b,
                                           input logic [DW-1:0] d);
        logic [DW+1:0] sh;
        sh = {rem, b};
        if (sh >= {2'b00, d})
            return {1'b1, sh[DW:0] - {1'b0, d}};
        return {1'b0, sh[DW:0]};
    endfunction

    // Returns {overflow, signed result}; the negative range is one larger than the positive one.
    function automatic logic [DW:0] fix(input logic [N-1:0] q, input logic neg);
        if (!neg && q > POS_MAX)
            return {1'b1, 1'b0, {(DW - 1){1'b1}}};
        if (neg && q > NEG_LIM)
            return {1'b1, 1'b1, {(DW - 1){1'b0}}};
        return {1'b0, neg ? -q[DW-1:0] : q[DW-1:0]};
    endfunction

    always_comb begin
        x_step = step(x_rem, x_dvd[N-1], p_mag);
        y_step = step(y_rem, y_dvd[N-1], p_mag);
        x_fix  = fix(x_q, sign_x);
        y_fix  = fix(y_q, sign_y);
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state        <= IDLE;
            cnt          <= '0;
            p_mag        <= '0;
            x_dvd        <= '0;
            y_dvd        <= '0;
            x_rem        <= '0;
            y_rem        <= '0;
            x_q          <= '0;
            y_q          <= '0;
            sign_x       <= 1'b0;
            sign_y       <= 1'b0;
            zero         <= 1'b0;
            ux_out       <= '0;
            uy_out       <= '0;
            div_valid    <= 1'b0;
            div_busy     <= 1'b0;
            div_by_zero  <= 1'b0;
            div_overflow <= 1'b0;
        end else begin
            div_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (div_start) begin
                        p_mag        <= mag(p_in);
                        x_dvd        <= {mag(pux_in), {FRAC_BITS{1'b0}}};
                        y_dvd        <= {mag(puy_in), {FRAC_BITS{1'b0}}};
                        sign_x       <= pux_in[DW-1] ^ p_in[DW-1];
                        sign_y       <= puy_in[DW-1] ^ p_in[DW-1];
                        zero         <= (p_in == '0);
                        cnt          <= '0;
                        x_rem        <= '0;
                        y_rem        <= '0;
                        x_q          <= '0;
                        y_q          <= '0;
                        ux_out       <= '0;
                        uy_out       <= '0;
                        div_by_zero  <= 1'b0;
                        div_overflow <= 1'b0;
                        div_busy     <= 1'b1;
                        state        <= ITER;
                    end
                end
                ITER: begin
                    x_rem <= x_step[DW:0];
                    y_rem <= y_step[DW:0];
                    x_q   <= {x_q[N-2:0], x_step[DW+1]};
                    y_q   <= {y_q[N-2:0], y_step[DW+1]};
                    x_dvd <= {x_dvd[N-2:0], 1'b0};
                    y_dvd <= {y_dvd[N-2:0], 1'b0};
                    cnt   <= cnt + 1'b1;
                    if (cnt == LAST_ITER)
                        state <= FIXUP;
                end
                FIXUP: begin
                    // A zero divisor yields all-ones quotients; the zero flag overrides them.
                    if (zero) begin
                        ux_out       <= '0;
                        uy_out       <= '0;
                        div_by_zero  <= 1'b1;
                        div_overflow <= 1'b0;
                    end else begin
                        ux_out       <= x_fix[DW-1:0];
                        uy_out       <= y_fix[DW-1:0];
                        div_overflow <= x_fix[DW] | y_fix[DW];
                    end
                    div_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    div_busy <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_moment_divider.sv
// Randomized and directed bench for moment_divider with a queue scoreboard and an arithmetic reference model.
module tb_moment_divider;

    logic        Clk = 1'b0;
    logic        Reset = 1'b0;
    logic        div_start = 1'b0;
    logic [31:0] p_in = '0, pux_in = '0, puy_in = '0;
    logic [31:0] ux_out, uy_out;
    logic        div_valid, div_busy, div_by_zero, div_overflow;

    moment_divider dut (
        .Clk(Clk), .Reset(Reset), .div_start(div_start),
        .p_in(p_in), .pux_in(pux_in), .puy_in(puy_in),
        .ux_out(ux_out), .uy_out(uy_out),
        .div_valid(div_valid), .div_busy(div_busy),
        .div_by_zero(div_by_zero), .div_overflow(div_overflow)
    );

    always #5 Clk = ~Clk;

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] ux;
        logic [31:0] uy;
        logic        dbz;
        logic        ovf;
        int          start;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    localparam longint QMAX = 64'sd2147483647;
    localparam longint QMIN = -QMAX - 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] ux, input logic [31:0] uy,
                                input logic dbz, input logic ovf);
        exp_t e;
        e.ux = ux; e.uy = uy; e.dbz = dbz; e.ovf = ovf; e.start = 0;
        return e;
    endfunction

    // Real-valued quotient of two Q16.16 numbers, truncated toward zero, clamped to 32 bits.
    function automatic logic [32:0] qdiv(input logic [31:0] n, input logic [31:0] d);
        longint q;
        q = (longint'($signed(n)) * 65536) / longint'($signed(d));
        if (q > QMAX) return {1'b1, 32'h7FFFFFFF};
        if (q < QMIN) return {1'b1, 32'h80000000};
        return {1'b0, q[31:0]};
    endfunction

    function automatic exp_t model(input logic [31:0] p, input logic [31:0] x, input logic [31:0] y);
        logic [32:0] rx, ry;
        if (p == 32'd0) return mk(32'd0, 32'd0, 1'b1, 1'b0);
        rx = qdiv(x, p);
        ry = qdiv(y, p);
        return mk(rx[31:0], ry[31:0], 1'b0, rx[32] | ry[32]);
    endfunction

    // Monitor: busy window and result checks against the scoreboard front.
    always @(negedge Clk) begin
        logic exp_busy;
        exp_t e;
        if (Reset) begin
            exp_busy = (sb.size() > 0) && (cyc >= sb[0].start + 1) && (cyc <= sb[0].start + 50);
            chk("busy", {31'd0, div_busy}, {31'd0, exp_busy});
            if (div_valid) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_valid: got div_valid=1 expected 0 (cycle %0d)", cyc);
                end else begin
                    e = sb.pop_front();
                    chk("valid_cycle", 32'(cyc), 32'(e.start + 50));
                    chk("ux", ux_out, e.ux);
                    chk("uy", uy_out, e.uy);
                    chk("div_by_zero", {31'd0, div_by_zero}, {31'd0, e.dbz});
                    chk("div_overflow", {31'd0, div_overflow}, {31'd0, e.ovf});
                end
            end else if (sb.size() > 0 && cyc > sb[0].start + 50) begin
                checks++;
                errors++;
                $display("FAIL missing_valid: got no div_valid expected at cycle %0d", sb[0].start + 50);
                void'(sb.pop_front());
            end
        end
    end

    task automatic issue(input logic [31:0] p, input logic [31:0] x, input logic [31:0] y,
                         input exp_t e, output int s);
        @(negedge Clk);
        p_in = p; pux_in = x; puy_in = y;
        div_start = 1'b1;
        s = cyc;
        e.start = cyc;
        sb.push_back(e);
        @(negedge Clk);
        div_start = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (sb.size() > 0 && n < 120) begin
            @(negedge Clk);
            n++;
        end
        if (sb.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL timeout: got %0d pending results expected 0", sb.size());
            sb.delete();
        end
        @(negedge Clk);
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_ux"}, ux_out, 32'd0);
        chk({tag, "_uy"}, uy_out, 32'd0);
        chk({tag, "_valid"}, {31'd0, div_valid}, 32'd0);
        chk({tag, "_busy"}, {31'd0, div_busy}, 32'd0);
        chk({tag, "_dbz"}, {31'd0, div_by_zero}, 32'd0);
        chk({tag, "_ovf"}, {31'd0, div_overflow}, 32'd0);
    endtask

    initial begin
        int   s;
        exp_t e;

        repeat (3) @(negedge Clk);
        #1 chk_zero_outputs("reset");
        Reset = 1'b1;

        // Directed cases with hand-derived expectations.
        issue(32'h00020000, 32'h00010000, 32'hFFFD0000, mk(32'h00008000, 32'hFFFE8000, 1'b0, 1'b0), s);
        wait_idle();
        issue(32'h00030000, 32'h00010000, 32'hFFFF0000, mk(32'h00005555, 32'hFFFFAAAB, 1'b0, 1'b0), s);
        wait_idle();
        issue(32'h00000000, 32'h00050000, 32'h12345678, mk(32'h0, 32'h0, 1'b1, 1'b0), s);
        wait_idle();
        issue(32'h00000100, 32'h7FFF0000, 32'h80010000, mk(32'h7FFFFFFF, 32'h80000000, 1'b0, 1'b1), s);
        wait_idle();
        issue(32'h00020000, 32'h00010000, 32'hFFFD0000, mk(32'h00008000, 32'hFFFE8000, 1'b0, 1'b0), s);
        wait_idle();

        // A start pulse mid-operation with new operands must be dropped.
        issue(32'h00020000, 32'h00010000, 32'hFFFD0000, mk(32'h00008000, 32'hFFFE8000, 1'b0, 1'b0), s);
        while (cyc < s + 10) @(negedge Clk);
        p_in = 32'h00000100; pux_in = 32'h7FFF0000; puy_in = 32'h00000000;
        div_start = 1'b1;
        @(negedge Clk);
        div_start = 1'b0;
        wait_idle();

        // Start held high: the second operation is taken on the first IDLE cycle after DONE.
        @(negedge Clk);
        p_in = 32'h00030000; pux_in = 32'h00010000; puy_in = 32'hFFFF0000;
        div_start = 1'b1;
        s = cyc;
        e = mk(32'h00005555, 32'hFFFFAAAB, 1'b0, 1'b0);
        e.start = s;
        sb.push_back(e);
        while (cyc < s + 51) @(negedge Clk);
        p_in = 32'h00000000; pux_in = 32'h00050000; puy_in = 32'h12345678;
        e = mk(32'h0, 32'h0, 1'b1, 1'b0);
        e.start = cyc;
        sb.push_back(e);
        @(negedge Clk);
        div_start = 1'b0;
        wait_idle();

        // Reset in the middle of an operation aborts it without a result.
        issue(32'h00020000, 32'h00010000, 32'hFFFD0000, mk(32'h00008000, 32'hFFFE8000, 1'b0, 1'b0), s);
        while (cyc < s + 20) @(negedge Clk);
        #2 Reset = 1'b0;
        #1 chk_zero_outputs("midreset");
        sb.delete();
        repeat (2) @(negedge Clk);
        Reset = 1'b1;
        issue(32'h00020000, 32'h00010000, 32'hFFFD0000, mk(32'h00008000, 32'hFFFE8000, 1'b0, 1'b0), s);
        wait_idle();

        // Randomized operands across the full dynamic range of p.
        for (int i = 0; i < 30; i++) begin
            logic [31:0] p, x, y;
            p = $urandom >> $urandom_range(31, 0);
            if ($urandom_range(1, 0) == 1) p = -p;
            x = $urandom;
            if ($urandom_range(1, 0) == 1) x = $signed(x) >>> $urandom_range(24, 0);
            y = $urandom;
            if ($urandom_range(1, 0) == 1) y = $signed(y) >>> $urandom_range(24, 0);
            issue(p, x, y, model(p, x, y), s);
            wait_idle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/moment_divider.md
Name: moment_divider

Overview:
Sequential fixed-point divider for the macroscopic-moment stage of the LBM pipeline. It computes velocity from the density-weighted moments: ux = pux / p and uy = puy / p. Two quotient datapaths run in parallel and share one denominator. The controller pulses div_start, waits for div_valid, then loads ux_out/uy_out into the UX/UY registers.

Parameters:
DATA_WIDTH, 32, width of all operands and results (two's complement fixed point)
FRAC_BITS, 16, fractional bits of operands and results (Q(DATA_WIDTH-FRAC_BITS).FRAC_BITS)
ITER_COUNT_WIDTH, $clog2(DATA_WIDTH+FRAC_BITS+1), width of the iteration counter

Ports:
Clk  input  1  system clock, rising edge
Reset  input  1  asynchronous, active-low reset
div_start  input  1  start request; sampled only in IDLE
p_in  input  DATA_WIDTH  density (denominator), signed
pux_in  input  DATA_WIDTH  p*ux moment (numerator x), signed
puy_in  input  DATA_WIDTH  p*uy moment (numerator y), signed
ux_out  output  DATA_WIDTH  quotient pux/p, signed fixed point
uy_out  output  DATA_WIDTH  quotient puy/p, signed fixed point
div_valid  output  1  single-cycle pulse: results ready
div_busy  output  1  high from accepted start until div_valid cycle inclusive
div_by_zero  output  1  p_in was 0 for this operation; valid with div_valid, held until next start
div_overflow  output  1  either quotient saturated; valid with div_valid, held until next start

Behaviour:
- Reset (async, Reset=0): state=IDLE; ux_out, uy_out = 0; div_valid, div_busy, div_by_zero, div_overflow = 0; internal registers cleared. Reset mid-operation aborts the operation with no div_valid.
- States: IDLE -> ITER -> FIXUP -> DONE -> IDLE.
- IDLE: when div_start=1 at a rising edge:
  - Latch |p_in|, |pux_in|, |puy_in| as DATA_WIDTH-bit unsigned magnitudes (|-2^(DATA_WIDTH-1)| = 2^(DATA_WIDTH-1) fits).
  - Latch sign_x = pux_in[MSB]^p_in[MSB] and sign_y = puy_in[MSB]^p_in[MSB].
  - Latch the zero flag (p_in==0), clear the iteration counter, go to ITER.
  - Operand changes after the sampling edge are ignored.
- ITER: exactly N = DATA_WIDTH+FRAC_BITS cycles of restoring division, one quotient bit per cycle per path, MSB first.
  - Dividend = magnitude << FRAC_BITS, N bits wide.
  - Partial remainder is DATA_WIDTH+1 bits.
  - Go to FIXUP after the counter reaches N-1.
- FIXUP (1 cycle): per path, take the unsigned N-bit quotient q.
  - If sign=0 and q > 2^(DATA_WIDTH-1)-1: saturate to 0x7FF..F and set overflow.
  - If sign=1 and q > 2^(DATA_WIDTH-1): saturate to 0x800..0 and set overflow.
  - Otherwise result = sign ? -q : q.
  - Rounding is truncation toward zero.
  - If the zero flag is set: both results = 0, div_by_zero=1, div_overflow=0.
  - Register the results into ux_out/uy_out.
- DONE (1 cycle): div_valid=1, then IDLE.
- Latency: div_start high in cycle 0 gives div_valid high in cycle N+2 (cycle 50 at defaults); div_busy is high in cycles 1..N+2.
- ux_out, uy_out, div_by_zero, div_overflow hold their values until the next accepted start. They are cleared at the accepted start edge.
- div_start while busy (ITER/FIXUP/DONE) is ignored, not queued. div_start held high continuously starts a new operation on the first IDLE cycle after DONE.
- p_in negative is legal (sign handled); no error flag.

Test Plan:
1. p=0x00020000 (2.0), pux=0x00010000 (1.0), puy=0xFFFD0000 (-3.0), 1-cycle start -> div_valid pulse exactly in cycle 50; ux=0x00008000, uy=0xFFFE8000; flags 0; div_busy high cycles 1..50.
2. Truncation: p=0x00030000, pux=0x00010000, puy=0xFFFF0000 -> ux=0x00005555, uy=0xFFFFAAAB.
3. Zero: p=0, pux=0x00050000, puy=0x12345678 -> ux=uy=0, div_by_zero=1, div_overflow=0, div_valid in cycle 50.
4. Overflow: p=0x00000100, pux=0x7FFF0000, puy=0x80010000 -> ux=0x7FFFFFFF, uy=0x80000000, div_overflow=1. Then a normal op (case 1) clears both flags.
5. Start pulsed at cycle 10 of an operation with changed operands -> ignored; first results unchanged, single div_valid. Back-to-back: start held high -> second op accepted at the cycle after DONE.
6. Reset driven low at cycle 20 of an operation -> all outputs 0 immediately; no div_valid. After release, a new start completes normally with case-1 results.
